// File: rtl/comparator_pkg.sv
// Shared definitions for the registered magnitude comparator.
//   DEFAULT_WIDTH / DEFAULT_CNT_W : default operand and statistics-counter widths
//   cmp_result_t                  : one-hot comparison result, bit order {Sm, Gt, Eq}
//   CMP_EQ / CMP_GT / CMP_SM      : the three legal result codes
package comparator_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = 8;

  typedef logic [2:0] cmp_result_t;

  localparam cmp_result_t CMP_EQ = 3'b001;
  localparam cmp_result_t CMP_GT = 3'b010;
  localparam cmp_result_t CMP_SM = 3'b100;

endpackage

// File: rtl/comparator_core.sv
// Purely combinational unsigned magnitude comparator.
// Ports:
//   i_a, i_b  : WIDTH-bit unsigned operands
//   o_result  : one-hot cmp_result_t (CMP_EQ, CMP_GT or CMP_SM)
module comparator_core
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output cmp_result_t      o_result
);

  always_comb begin
    o_result = CMP_EQ;
    if (i_a > i_b) begin
      o_result = CMP_GT;
    end else if (i_a < i_b) begin
      o_result = CMP_SM;
    end
  end

endmodule

// File: rtl/comparator_4bit_bh.sv
// Registered magnitude comparator: one-hot Eq/Gt/Sm flags and out_valid appear one clock after
// a sample accepted with in_valid. Flags hold between samples; rst (synchronous, active-high)
// clears everything and takes priority over in_valid.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid, A, B           : sample qualifier and unsigned operands
//   Eq, Gt, Sm, out_valid    : registered result flags and one-cycle result strobe
//   eq_cnt, gt_cnt, sm_cnt   : saturating outcome counters (only with CMP_STATS_EN defined)
// Optional feature macro: CMP_STATS_EN.
module comparator_4bit_bh
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Eq,
  output logic             Gt,
  output logic             Sm,
  output logic             out_valid
`ifdef CMP_STATS_EN
  ,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] sm_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
    $error("comparator_4bit_bh: illegal WIDTH or CNT_W");
  end

  cmp_result_t w_result;
  cmp_result_t r_result;
  logic        r_valid;

  comparator_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (A),
    .i_b      (B),
    .o_result (w_result)
  );

  // Result only loads on accepted samples, so X on A/B while idle never reaches the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result;
      end
    end
  end

  assign Eq        = r_result[0];
  assign Gt        = r_result[1];
  assign Sm        = r_result[2];
  assign out_valid = r_valid;

`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_sm_cnt;

  // Saturating counters: stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eq_cnt <= '0;
      r_gt_cnt <= '0;
      r_sm_cnt <= '0;
    end else if (in_valid) begin
      unique case (w_result)
        CMP_EQ: if (r_eq_cnt != '1) r_eq_cnt <= r_eq_cnt + CNT_W'(1);
        CMP_GT: if (r_gt_cnt != '1) r_gt_cnt <= r_gt_cnt + CNT_W'(1);
        CMP_SM: if (r_sm_cnt != '1) r_sm_cnt <= r_sm_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign eq_cnt = r_eq_cnt;
  assign gt_cnt = r_gt_cnt;
  assign sm_cnt = r_sm_cnt;
`endif

endmodule

// File: tb/tb_comparator_4bit_bh.sv
// Scoreboard bench for comparator_4bit_bh: the stimulus process pushes the expected flags of
// every accepted sample; an independent monitor pops and compares whenever out_valid is seen,
// and otherwise checks that flags hold (or are cleared after rst).
module tb_comparator_4bit_bh;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Eq, Gt, Sm, out_valid;
`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] eq_cnt, gt_cnt, sm_cnt;
`endif

  comparator_4bit_bh #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Eq        (Eq),
    .Gt        (Gt),
    .Sm        (Sm),
    .out_valid (out_valid)
`ifdef CMP_STATS_EN
    ,
    .eq_cnt    (eq_cnt),
    .gt_cnt    (gt_cnt),
    .sm_cnt    (sm_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];  // {Sm, Gt, Eq}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
  endtask

  // Reference: plain unsigned arithmetic comparison.
  function automatic logic [2:0] ref_cmp(input int unsigned a, input int unsigned b);
    if (a == b) return 3'b001;
    if (a > b)  return 3'b010;
    return 3'b100;
  endfunction

  task automatic drive(input logic v, input int unsigned a, input int unsigned b, input logic r);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = WIDTH'(a);
    B        = WIDTH'(b);
    if (v && !r) exp_q.push_back(ref_cmp(int'(A), int'(B)));
  endtask

  // Monitor
  initial begin : monitor
    logic [2:0] held;
    logic [2:0] e;
    logic       r_seen;
    int         cnt[3];
    int         sat;
    held = 3'b000;
    cnt  = '{0, 0, 0};
    sat  = (1 << CNT_W) - 1;
    forever begin
      @(posedge clk);
      r_seen = rst;
      #1;
      if (r_seen) begin
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_flags", 32'({Sm, Gt, Eq}), 0);
        held = 3'b000;
        cnt  = '{0, 0, 0};
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("flags", 32'({Sm, Gt, Eq}), 32'(e));
          held = e;
          for (int i = 0; i < 3; i++) begin
            if (e[i] && cnt[i] < sat) cnt[i]++;
          end
        end
      end else begin
        check("hold_flags", 32'({Sm, Gt, Eq}), 32'(held));
      end
`ifdef CMP_STATS_EN
      check("eq_cnt", 32'(eq_cnt), 32'(cnt[0]));
      check("gt_cnt", 32'(gt_cnt), 32'(cnt[1]));
      check("sm_cnt", 32'(sm_cnt), 32'(cnt[2]));
`endif
    end
  end

  // Stimulus
  initial begin : stimulus
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    // Basic equal, then back-to-back Gt / Sm / Eq
    drive(1, 4'b1010, 4'b1010, 0);
    drive(1, 4'b1110, 4'b1010, 0);
    drive(1, 4'b1010, 4'b1011, 0);
    drive(1, 4'b1001, 4'b1001, 0);
    // Unsigned boundaries
    drive(1, 4'b0000, 4'b1111, 0);
    drive(1, 4'b1111, 4'b0000, 0);
    drive(1, 4'b0000, 4'b0000, 0);
    // Idle with toggling operands: flags must hold
    repeat (4) drive(0, $urandom, $urandom, 0);
    // rst together with a valid sample discards it
    drive(1, 4'b1110, 4'b1010, 1);
    drive(1, 4'b0011, 4'b0101, 0);
    drive(0, 0, 0, 0);
    // Repeated Eq samples saturate a narrow counter
    repeat (5) drive(1, 4'b0111, 4'b0111, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    // Randomized traffic with occasional reset
    repeat (400) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 31) == 0));
    end
    repeat (3) drive(0, 0, 0, 0);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
